// File: rtl/stacker_pkg.sv
// rtl/stacker_pkg.sv - shared types and widths for the block-stacker game sequencer
//
// Contents:
//   state_t    game FSM encoding (IDLE, SPAWN, MOVE, CHECK, COMMIT, GAME_OVER, WIN)
//   dir_t      moving block direction (DIR_L, DIR_R)
//   POS_W      pixel position width
//   SIZE_W     block size / level width
//   OV_W       widened overlap arithmetic width (keeps max/min/span free of wrap)
//   max_ov / min_ov  overlap helpers

package stacker_pkg;

   localparam int POS_W  = 9;
   localparam int SIZE_W = 4;
   localparam int OV_W   = 10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SPAWN     = 3'd1,
      MOVE      = 3'd2,
      CHECK     = 3'd3,
      COMMIT    = 3'd4,
      GAME_OVER = 3'd5,
      WIN       = 3'd6
   } state_t;

   typedef enum logic {
      DIR_L = 1'b0,
      DIR_R = 1'b1
   } dir_t;

   function automatic logic [OV_W-1:0] max_ov(input logic [OV_W-1:0] a, input logic [OV_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [OV_W-1:0] min_ov(input logic [OV_W-1:0] a, input logic [OV_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/stacker_step_timer.sv
// rtl/stacker_step_timer.sv - step period counter with freeze and one-cycle step pulse
//
// Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   clear   in   force the counter back to 0
//   en      in   count enable; low freezes the counter
//   period  in   cycles per step (values below 1 behave as 1)
//   step    out  high for the enabled cycle in which the count reaches period-1

module stacker_step_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   output logic             step
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] last;

   // Period 0 would underflow; treat it as a step every enabled cycle.
   assign last = (period == '0) ? '0 : period - CNT_W'(1);

   always_comb begin
      cnt_d = cnt_q;
      step  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         // >= rather than == so a shortened period never lets the count run away.
         if (cnt_q >= last) begin
            step  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stack_game_ctrl.sv
// rtl/stack_game_ctrl.sv - block-stacker game sequencer (move, stop, overlap trim, level/win/miss)
//
// Optional feature macro: SPEEDUP_EN (step period = MOVE_DIV >> (level-1), floor 1 cycle);
// undefined, the step period is a constant MOVE_DIV.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start                  1-cycle pulse, begins a game from IDLE/GAME_OVER/WIN
//   stop_btn               synchronised stop level; rising edge stops the block in MOVE
//   draw_ack / draw_req    handshake with the downstream drawer
//   cur_start/end/size     moving block (px inclusive, units)
//   prev_start/end/size    last committed block (px inclusive, units)
//   level                  committed rows so far
//   game_over, win         state flags

module stack_game_ctrl
   import stacker_pkg::*;
#(
   parameter int unsigned X_MAX     = 160,
   parameter int unsigned UNIT_W    = 8,
   parameter int unsigned INIT_SIZE = 4,
   parameter int unsigned LEVELS    = 10,
   parameter int unsigned MOVE_DIV  = 500000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop_btn,
   input  logic              draw_ack,
   output logic              draw_req,
   output logic [POS_W-1:0]  cur_start,
   output logic [POS_W-1:0]  cur_end,
   output logic [SIZE_W-1:0] cur_size,
   output logic [POS_W-1:0]  prev_start,
   output logic [POS_W-1:0]  prev_end,
   output logic [SIZE_W-1:0] prev_size,
   output logic [SIZE_W-1:0] level,
   output logic              game_over,
   output logic              win
);

   localparam int unsigned INIT_PX    = INIT_SIZE * UNIT_W;
   localparam int unsigned INIT_START = ((X_MAX - INIT_PX) / 2 / UNIT_W) * UNIT_W;

   localparam logic [POS_W-1:0]  X_LAST_P     = POS_W'(X_MAX - 1);
   localparam logic [POS_W-1:0]  UNIT_P       = POS_W'(UNIT_W);
   localparam logic [POS_W-1:0]  INIT_START_P = POS_W'(INIT_START);
   localparam logic [POS_W-1:0]  INIT_END_P   = POS_W'(INIT_START + INIT_PX - 1);
   localparam logic [SIZE_W-1:0] INIT_SIZE_S  = SIZE_W'(INIT_SIZE);
   localparam logic [SIZE_W-1:0] LEVELS_S     = SIZE_W'(LEVELS);
   localparam logic [31:0]       MOVE_DIV_L   = 32'(MOVE_DIV);

   state_t             state_q,      state_d;
   dir_t               dir_q,        dir_d;
   logic               stop_prev_q,  stop_prev_d;
   logic               draw_req_q,   draw_req_d;
   logic [POS_W-1:0]   cur_start_q,  cur_start_d;
   logic [POS_W-1:0]   cur_end_q,    cur_end_d;
   logic [SIZE_W-1:0]  cur_size_q,   cur_size_d;
   logic [POS_W-1:0]   prev_start_q, prev_start_d;
   logic [POS_W-1:0]   prev_end_q,   prev_end_d;
   logic [SIZE_W-1:0]  prev_size_q,  prev_size_d;
   logic [SIZE_W-1:0]  level_q,      level_d;

   logic               stop_edge;
   logic               step;
   logic               timer_clear;
   logic               timer_en;
   logic               draw_set;
   logic [31:0]        period;

   logic [OV_W-1:0]    ov_start;
   logic [OV_W-1:0]    ov_end;
   logic [OV_W-1:0]    ov_span;
   logic               ov_hit;
   logic [SIZE_W-1:0]  ov_size;
   logic [SIZE_W-1:0]  level_inc;

   assign stop_edge = stop_btn & ~stop_prev_q;

`ifdef SPEEDUP_EN
   logic [31:0] period_shift;
   assign period_shift = MOVE_DIV_L >> (level_q - SIZE_W'(1));
   assign period       = (period_shift == 32'd0) ? 32'd1 : period_shift;
`else
   assign period = MOVE_DIV_L;
`endif

   // Counter runs only in MOVE and holds while the drawer owes an ack.
   assign timer_en = (state_q == MOVE) && !draw_req_q;

   stacker_step_timer #(.CNT_W(32)) u_step_timer (
      .clk    (clk),
      .resetn (resetn),
      .clear  (timer_clear),
      .en     (timer_en),
      .period (period),
      .step   (step)
   );

   // cur/prev are stable across CHECK and COMMIT, so the overlap is combinational
   // and used by both states without extra storage.
   assign ov_start  = max_ov({1'b0, cur_start_q}, {1'b0, prev_start_q});
   assign ov_end    = min_ov({1'b0, cur_end_q},   {1'b0, prev_end_q});
   assign ov_hit    = (ov_start <= ov_end);
   assign ov_span   = ov_end - ov_start + OV_W'(1);
   assign ov_size   = SIZE_W'(ov_span / OV_W'(UNIT_W));
   assign level_inc = level_q + SIZE_W'(1);

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      stop_prev_d  = stop_btn;
      cur_start_d  = cur_start_q;
      cur_end_d    = cur_end_q;
      cur_size_d   = cur_size_q;
      prev_start_d = prev_start_q;
      prev_end_d   = prev_end_q;
      prev_size_d  = prev_size_q;
      level_d      = level_q;
      draw_set     = 1'b0;
      timer_clear  = 1'b0;

      case (state_q)
         IDLE, GAME_OVER, WIN: begin
            if (start) begin
               prev_start_d = INIT_START_P;
               prev_end_d   = INIT_END_P;
               prev_size_d  = INIT_SIZE_S;
               cur_size_d   = INIT_SIZE_S;
               level_d      = SIZE_W'(1);
               state_d      = SPAWN;
            end
         end

         SPAWN: begin
            cur_start_d = '0;
            cur_end_d   = POS_W'(cur_size_q) * UNIT_P - POS_W'(1);
            dir_d       = DIR_R;
            timer_clear = 1'b1;
            draw_set    = 1'b1;
            state_d     = MOVE;
         end

         MOVE: begin
            // A stop in the same cycle as a step discards the step.
            if (stop_edge) begin
               state_d = CHECK;
            end else if (step) begin
               draw_set = 1'b1;
               if (dir_q == DIR_R) begin
                  if (cur_end_q == X_LAST_P) begin
                     dir_d       = DIR_L;
                     cur_start_d = cur_start_q - UNIT_P;
                     cur_end_d   = cur_end_q - UNIT_P;
                  end else begin
                     cur_start_d = cur_start_q + UNIT_P;
                     cur_end_d   = cur_end_q + UNIT_P;
                  end
               end else begin
                  if (cur_start_q == '0) begin
                     dir_d       = DIR_R;
                     cur_start_d = cur_start_q + UNIT_P;
                     cur_end_d   = cur_end_q + UNIT_P;
                  end else begin
                     cur_start_d = cur_start_q - UNIT_P;
                     cur_end_d   = cur_end_q - UNIT_P;
                  end
               end
            end
         end

         CHECK: begin
            if (ov_hit) begin
               state_d = COMMIT;
            end else begin
               draw_set = 1'b1;
               state_d  = GAME_OVER;
            end
         end

         COMMIT: begin
            prev_start_d = ov_start[POS_W-1:0];
            prev_end_d   = ov_end[POS_W-1:0];
            prev_size_d  = ov_size;
            cur_size_d   = ov_size;
            level_d      = level_inc;
            draw_set     = 1'b1;
            state_d      = (level_inc == LEVELS_S) ? WIN : SPAWN;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Set-dominant: an ack only clears when nothing new was posted this cycle.
      draw_req_d = draw_set | (draw_req_q & ~draw_ack);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         dir_q        <= DIR_R;
         stop_prev_q  <= 1'b0;
         draw_req_q   <= 1'b0;
         cur_start_q  <= '0;
         cur_end_q    <= '0;
         cur_size_q   <= '0;
         prev_start_q <= '0;
         prev_end_q   <= '0;
         prev_size_q  <= '0;
         level_q      <= '0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         stop_prev_q  <= stop_prev_d;
         draw_req_q   <= draw_req_d;
         cur_start_q  <= cur_start_d;
         cur_end_q    <= cur_end_d;
         cur_size_q   <= cur_size_d;
         prev_start_q <= prev_start_d;
         prev_end_q   <= prev_end_d;
         prev_size_q  <= prev_size_d;
         level_q      <= level_d;
      end
   end

   assign draw_req   = draw_req_q;
   assign cur_start  = cur_start_q;
   assign cur_end    = cur_end_q;
   assign cur_size   = cur_size_q;
   assign prev_start = prev_start_q;
   assign prev_end   = prev_end_q;
   assign prev_size  = prev_size_q;
   assign level      = level_q;
   assign game_over  = (state_q == GAME_OVER);
   assign win        = (state_q == WIN);

endmodule

// File: tb/tb_stack_game_ctrl.sv
// tb/tb_stack_game_ctrl.sv - self-checking bench for stack_game_ctrl (LEVELS=3, MOVE_DIV=4)

module tb_stack_game_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       stop_btn = 1'b0;
   logic       draw_ack = 1'b0;
   logic       draw_req;
   logic [8:0] cur_start, cur_end, prev_start, prev_end;
   logic [3:0] cur_size, prev_size, level;
   logic       game_over, win;

   int checks = 0;
   int failures = 0;

   stack_game_ctrl #(
      .X_MAX(160), .UNIT_W(8), .INIT_SIZE(4), .LEVELS(3), .MOVE_DIV(4)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop_btn(stop_btn), .draw_ack(draw_ack),
      .draw_req(draw_req), .cur_start(cur_start), .cur_end(cur_end), .cur_size(cur_size),
      .prev_start(prev_start), .prev_end(prev_end), .prev_size(prev_size),
      .level(level), .game_over(game_over), .win(win)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start, stop, ack;
      logic       dr;
      logic [8:0] cs, ce, ps, pe;
      logic [3:0] csz, psz, lvl;
      logic       go, wn;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int dr, input int cs, input int ce, input int csz,
                            input int ps, input int pe, input int psz, input int lvl,
                            input int go, input int wn);
      chk({tag, ".draw_req"},   int'(draw_req),   dr);
      chk({tag, ".cur_start"},  int'(cur_start),  cs);
      chk({tag, ".cur_end"},    int'(cur_end),    ce);
      chk({tag, ".cur_size"},   int'(cur_size),   csz);
      chk({tag, ".prev_start"}, int'(prev_start), ps);
      chk({tag, ".prev_end"},   int'(prev_end),   pe);
      chk({tag, ".prev_size"},  int'(prev_size),  psz);
      chk({tag, ".level"},      int'(level),      lvl);
      chk({tag, ".game_over"},  int'(game_over),  go);
      chk({tag, ".win"},        int'(win),        wn);
   endtask

   // Drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic tick(input logic s, input logic st, input logic a);
      @(negedge clk);
      start    = s;
      stop_btn = st;
      draw_ack = a;
      @(posedge clk);
      #1;
   endtask

   // Ack the pending draw, then expect the next step exactly 4 cycles later.
   task automatic do_step(input string tag, input int exp_s, input int exp_e);
      int n;
      tick(1'b0, 1'b0, 1'b1);
      chk({tag, ".ack_clears"}, int'(draw_req), 0);
      n = 0;
      for (int k = 1; k <= 10; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (draw_req) begin
            n = k;
            break;
         end
      end
      chk({tag, ".step_latency"}, n, 4);
      chk({tag, ".cur_start"}, int'(cur_start), exp_s);
      chk({tag, ".cur_end"},   int'(cur_end),   exp_e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           start stop ack  dr   cs     ce      ps      pe      csz   psz   lvl   go    wn
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0,  9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd31, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};
      vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 9'd8, 9'd39, 9'd64, 9'd95, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0};

      // Reset held two cycles with stop activity; everything stays 0.
      resetn = 1'b0;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("idle_stop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Game start, spawn, frozen counter until ack, first step.
      for (int i = 0; i < 10; i++) begin
         tick(vt[i].start, vt[i].stop, vt[i].ack);
         check_all($sformatf("vec%0d", i), int'(vt[i].dr), int'(vt[i].cs), int'(vt[i].ce),
                   int'(vt[i].csz), int'(vt[i].ps), int'(vt[i].pe), int'(vt[i].psz),
                   int'(vt[i].lvl), int'(vt[i].go), int'(vt[i].wn));
      end

      // Trim: stop at 80 over 64..95.
      for (int k = 2; k <= 10; k++) do_step($sformatf("to80_%0d", k), 8 * k, 8 * k + 31);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check_all("commit1", 1, 80, 111, 2, 80, 95, 2, 2, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("respawn2", 1, 0, 15, 2, 80, 95, 2, 2, 0, 0);

      // Miss at 0..15 against 80..95.
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check_all("miss", 1, 0, 15, 2, 80, 95, 2, 2, 1, 0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("go_stop_ignored", 0, 0, 15, 2, 80, 95, 2, 2, 1, 0);
      tick(1'b1, 1'b0, 1'b0);
      check_all("restart", 0, 0, 15, 4, 64, 95, 4, 1, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("restart_spawn", 1, 0, 31, 4, 64, 95, 4, 1, 0, 0);

      // Bounce off the right wall and back off the left wall.
      for (int k = 1; k <= 16; k++) do_step($sformatf("right_%0d", k), 8 * k, 8 * k + 31);
      do_step("bounce_r", 120, 151);
      for (int k = 14; k >= 0; k--) do_step($sformatf("left_%0d", k), 8 * k, 8 * k + 31);
      do_step("bounce_l", 8, 39);

      // Stop in the same cycle a step would fire: block stays at 64.
      for (int k = 2; k <= 8; k++) do_step($sformatf("to64_%0d", k), 8 * k, 8 * k + 31);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      chk("stop_vs_step.cur_start", int'(cur_start), 64);
      chk("stop_vs_step.draw_req", int'(draw_req), 0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check_all("perfect1", 1, 64, 95, 4, 64, 95, 4, 2, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      check_all("perfect1_spawn", 1, 0, 31, 4, 64, 95, 4, 2, 0, 0);

      // Second perfect stop reaches LEVELS.
      for (int k = 1; k <= 8; k++) do_step($sformatf("lvl2_%0d", k), 8 * k, 8 * k + 31);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check_all("win", 1, 64, 95, 4, 64, 95, 4, 3, 0, 1);
      tick(1'b0, 1'b0, 1'b0);
      check_all("win_hold", 1, 64, 95, 4, 64, 95, 4, 3, 0, 1);

      // Restart from WIN, then reset in the middle of MOVE.
      tick(1'b1, 1'b0, 1'b0);
      check_all("win_restart", 1, 64, 95, 4, 64, 95, 4, 1, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      do_step("final_step", 8, 39);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      tick(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0);
      check_all("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
